// File: rtl/store_unit_pkg.sv
// Shared wires for the store unit: op encoding, queue entry and port bundles.
package store_unit_pkg;

  // One-hot store size, bit order {sw, sh, sb}
  typedef enum logic [2:0] {
    OP_SB = 3'b001,
    OP_SH = 3'b010,
    OP_SW = 3'b100
  } store_op_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sq_entry_t;

  typedef struct packed {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_op;
    logic        mem_ready;
  } store_unit_in_type;

  typedef struct packed {
    logic        st_ready;
    logic        st_error;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        empty;
  } store_unit_out_type;

endpackage

// File: rtl/store_align.sv
// Byte-lane replication, strobe generation and misalignment detection for one store.
module store_align
  import store_unit_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [2:0]  op,
  output sq_entry_t   entry,
  output logic        misalign
);

  always_comb begin
    entry.addr  = {addr[31:2], 2'b00};
    entry.wdata = data;
    entry.wstrb = 4'h0;
    misalign    = 1'b0;
    case (store_op_e'(op))
      OP_SB: begin
        entry.wdata = {4{data[7:0]}};
        entry.wstrb = 4'b0001 << addr[1:0];
      end
      OP_SH: begin
        entry.wdata = {2{data[15:0]}};
        entry.wstrb = addr[1] ? 4'hC : 4'h3;
        misalign    = addr[0];
      end
      OP_SW: begin
        entry.wstrb = 4'hF;
        misalign    = |addr[1:0];
      end
      // anything not one-hot is illegal
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// In-order store queue: aligns core stores and issues them to memory one word at a time.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_op,
  output logic        st_error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  store_unit_in_type  si;
  store_unit_out_type so;

  sq_entry_t         fifo [DEPTH];
  sq_entry_t         new_ent;
  logic              misalign;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              hs, push, pop, err_q;

  assign si.st_valid  = st_valid;
  assign si.st_addr   = st_addr;
  assign si.st_data   = st_data;
  assign si.st_op     = st_op;
  assign si.mem_ready = mem_ready;

  store_align u_align (
    .addr     (si.st_addr),
    .data     (si.st_data),
    .op       (si.st_op),
    .entry    (new_ent),
    .misalign (misalign)
  );

  assign so.st_ready  = count < CW'(DEPTH);
  assign so.mem_valid = count != '0;
  assign so.empty     = count == '0;
  assign so.st_error  = err_q;
  assign so.mem_addr  = fifo[head].addr;
  assign so.mem_wdata = fifo[head].wdata;
  assign so.mem_wstrb = fifo[head].wstrb;

  assign hs   = si.st_valid & so.st_ready;
  assign push = hs & ~misalign;
  assign pop  = so.mem_valid & si.mem_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= hs & misalign;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is deliberately unreset; count gates its visibility.
  always_ff @(posedge clock) begin
    if (push) fifo[tail] <= new_ent;
  end

  assign st_ready  = so.st_ready;
  assign st_error  = so.st_error;
  assign mem_valid = so.mem_valid;
  assign mem_addr  = so.mem_addr;
  assign mem_wdata = so.mem_wdata;
  assign mem_wstrb = so.mem_wstrb;
  assign empty     = so.empty;

endmodule

// File: tb/tb_store_unit.sv
// Store unit bench: queue-based reference model checked every cycle, plus directed literal cases.
module tb_store_unit;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        st_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_op = '0;
  logic        st_ready, st_error, mem_valid, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } mref_t;

  mref_t q[$];
  bit    m_err = 1'b0;
  bit    m_live = 1'b0;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_op     (st_op),
    .st_error  (st_error),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected memory word for a store, from the byte-lane rules; returns 0 if illegal.
  function automatic bit model_store(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] d, output mref_t e);
    e.a = a & 32'hFFFF_FFFC;
    e.d = 32'h0;
    e.s = 4'h0;
    if (op == 3'b001) begin
      e.s = 4'(1 << (a % 4));
      e.d = (d & 32'hFF) * 32'h0101_0101;
      return 1'b1;
    end else if (op == 3'b010) begin
      if (a % 2 != 0) return 1'b0;
      e.s = (a % 4 >= 2) ? 4'hC : 4'h3;
      e.d = (d & 32'hFFFF) * 32'h0001_0001;
      return 1'b1;
    end else if (op == 3'b100) begin
      if (a % 4 != 0) return 1'b0;
      e.s = 4'hF;
      e.d = d;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    mref_t e;
    bit    ok, acc;
    if (reset) begin
      q.delete();
      m_err  = 1'b0;
      m_live = 1'b1;
    end else begin
      acc = st_valid && (q.size() < DEPTH);
      ok  = model_store(st_op, st_addr, st_data, e);
      if (q.size() != 0 && mem_ready) void'(q.pop_front());
      if (acc && ok) q.push_back(e);
      m_err = acc && !ok;
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
      chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("st_error", 32'(st_error), 32'(m_err));
      if (q.size() != 0) begin
        chk("mem_addr", mem_addr, q[0].a);
        chk("mem_wdata", mem_wdata, q[0].d);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].s));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (st_ready) begin
        step();
        st_valid = 1'b0;
        return;
      end
      step();
    end
    chk("push_timeout", 32'd0, 32'd1);
    st_valid = 1'b0;
  endtask

  task automatic drain();
    mem_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (empty) return;
      step();
    end
    chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] op;
    step();
    step();
    reset = 1'b0;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_st_error", 32'(st_error), 32'd0);

    // sb into byte lane 3, visible the cycle after acceptance
    mem_ready = 1'b0;
    push(3'b001, 32'h0000_1003, 32'h0000_00AB);
    chk("sb_valid", 32'(mem_valid), 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_strb", 32'(mem_wstrb), 32'h8);
    chk("sb_data", mem_wdata, 32'hABAB_ABAB);
    drain();

    mem_ready = 1'b0;
    push(3'b010, 32'h0000_2002, 32'h1234_CAFE);
    chk("sh_strb", 32'(mem_wstrb), 32'hC);
    chk("sh_data", mem_wdata, 32'hCAFE_CAFE);
    drain();

    mem_ready = 1'b0;
    push(3'b100, 32'h0000_3000, 32'hDEAD_BEEF);
    chk("sw_strb", 32'(mem_wstrb), 32'hF);
    chk("sw_data", mem_wdata, 32'hDEAD_BEEF);
    drain();

    // misaligned halfword: dropped, one-cycle error pulse
    push(3'b010, 32'h0000_2001, 32'h0000_5555);
    chk("mis_err", 32'(st_error), 32'd1);
    chk("mis_valid", 32'(mem_valid), 32'd0);
    chk("mis_empty", 32'(empty), 32'd1);
    step();
    chk("mis_err_clr", 32'(st_error), 32'd0);
    chk("mis_empty2", 32'(empty), 32'd1);

    // back-pressure: third store stalls until memory drains
    mem_ready = 1'b0;
    push(3'b100, 32'h0000_5000, 32'h1111_1111);
    push(3'b100, 32'h0000_5004, 32'h2222_2222);
    chk("bp_ready_low", 32'(st_ready), 32'd0);
    st_valid = 1'b1;
    st_op    = 3'b100;
    st_addr  = 32'h0000_5008;
    st_data  = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_addr", mem_addr, 32'h0000_5000);
      chk("bp_hold_data", mem_wdata, 32'h1111_1111);
    end
    mem_ready = 1'b1;
    push(3'b100, 32'h0000_5008, 32'h3333_3333);
    drain();

    // steady state at count=1: accept and pop every cycle
    mem_ready = 1'b0;
    push(3'b100, 32'h0000_3FFC, 32'hFFFF_FFFF);
    mem_ready = 1'b1;
    st_valid  = 1'b1;
    st_op     = 3'b100;
    for (int i = 0; i < 10; i++) begin
      st_addr = 32'h0000_4000 + 32'(i * 4);
      st_data = 32'(i);
      chk("ss_head", mem_addr, 32'h0000_4000 + 32'(i * 4) - 32'd4);
      chk("ss_ready", 32'(st_ready), 32'd1);
      step();
      chk("ss_valid", 32'(mem_valid), 32'd1);
    end
    st_valid = 1'b0;
    drain();

    // reset with a full queue discards everything
    mem_ready = 1'b0;
    push(3'b100, 32'h0000_6000, 32'hAAAA_AAAA);
    push(3'b100, 32'h0000_6004, 32'hBBBB_BBBB);
    chk("pre_rst_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_ready", 32'(st_ready), 32'd1);
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 32'(mem_valid), 32'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      st_valid  = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       op = 3'b001;
        1:       op = 3'b010;
        2, 3:    op = 3'b100;
        default: op = 3'($urandom_range(0, 7));
      endcase
      st_op   = op;
      st_addr = $urandom;
      if ($urandom_range(0, 3) != 0) st_addr[1:0] = (op == 3'b100) ? 2'b00 : {st_addr[1], 1'b0};
      st_data = $urandom;
      step();
    end
    reset    = 1'b0;
    st_valid = 1'b0;
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
